// File: rtl/dp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dp_pkg
//  Description : Shared defaults, FSM state type and width helper for the
//                streaming dot-product MAC.
//  Revision    : 1.0 - initial release
// ============================================================================
package dp_pkg;

    localparam int DP_ELEM_W  = 5;
    localparam int DP_VEC_LEN = 4;
    localparam int DP_ACC_W   = 16;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } dp_state_t;

    // Smallest accumulator that can hold VEC_LEN full-scale signed products
    function automatic int dp_min_acc_w(input int elem_w, input int vec_len);
        return 2 * elem_w + $clog2(vec_len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dp_mult_stage.sv
`default_nettype none
// ============================================================================
//  Module      : dp_mult_stage
//  Description : Registered signed multiplier (pipeline stage 1) with a
//                companion valid bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module dp_mult_stage
    import dp_pkg::*;
#(
    parameter int ELEM_W = DP_ELEM_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [ELEM_W-1:0]     a,
    input  logic [ELEM_W-1:0]     b,
    output logic [2*ELEM_W-1:0]   p,
    output logic                  p_vld
);

    localparam int c_P_W = 2 * ELEM_W;

    logic signed [c_P_W-1:0] w_a_ext;
    logic signed [c_P_W-1:0] w_b_ext;
    logic signed [c_P_W-1:0] w_prod;

    // Sign-extend to the product width so the truncated product is exact
    assign w_a_ext = {{ELEM_W{a[ELEM_W-1]}}, a};
    assign w_b_ext = {{ELEM_W{b[ELEM_W-1]}}, b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Capture the product of each accepted pair; valid follows the accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p     <= '0;
            p_vld <= 1'b0;
        end else begin
            p_vld <= en;
            if (en) begin
                p <= w_prod;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dot_product_stream_mac.sv
`default_nettype none
// ============================================================================
//  Module      : dot_product_stream_mac
//  Description : Streaming signed dot product. Accepts one (a, b) pair per
//                handshake, accumulates VEC_LEN products and presents one
//                result with a framing-error flag per vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module dot_product_stream_mac
    import dp_pkg::*;
#(
    parameter int ELEM_W  = DP_ELEM_W,
    parameter int VEC_LEN = DP_VEC_LEN,
    parameter int ACC_W   = DP_ACC_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ELEM_W-1:0]   in_a,
    input  logic [ELEM_W-1:0]   in_b,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    out_result,
    output logic                out_err
);

    localparam int c_P_W   = 2 * ELEM_W;
    localparam int c_CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(VEC_LEN - 1);

    generate
        if (VEC_LEN < 2 || ACC_W < dp_min_acc_w(ELEM_W, VEC_LEN)) begin : g_param_check
            $error("dot_product_stream_mac: VEC_LEN must be >= 2 and ACC_W >= 2*ELEM_W+clog2(VEC_LEN)");
        end
    endgenerate

    dp_state_t            r_state;
    dp_state_t            w_state_nxt;
    logic [c_CNT_W-1:0]   r_count;
    logic [ACC_W-1:0]     r_acc;
    logic                 r_err;
    logic                 w_accept;
    logic                 w_out_hs;
    logic                 w_is_last_slot;
    logic [c_P_W-1:0]     w_p;
    logic                 w_p_vld;
    logic [ACC_W-1:0]     w_p_ext;

    assign w_accept       = in_valid && in_ready;
    assign w_out_hs       = out_valid && out_ready;
    assign w_is_last_slot = (r_count == c_CNT_LAST);
    assign w_p_ext        = {{(ACC_W - c_P_W){w_p[c_P_W-1]}}, w_p};

    assign out_result = r_acc;
    assign out_err    = r_err;

    dp_mult_stage #(
        .ELEM_W (ELEM_W)
    ) u_mult (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (w_accept),
        .a      (in_a),
        .b      (in_b),
        .p      (w_p),
        .p_vld  (w_p_vld)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; in_ready is held low throughout reset
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ACCUM: begin
                in_ready = rst_n;
                if (w_accept && w_is_last_slot) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ACCUM;
                end
            end
            default: begin
                w_state_nxt = ACCUM;
            end
        endcase
    end

    // Element counter; the count alone closes a vector, not in_last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= w_is_last_slot ? '0 : r_count + 1'b1;
        end
    end

    // Stage 2 accumulator; cleared when the held result is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_out_hs) begin
            r_acc <= '0;
        end else if (w_p_vld) begin
            r_acc <= r_acc + w_p_ext;
        end
    end

    // Sticky framing error: in_last must coincide exactly with the final slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_out_hs) begin
            r_err <= 1'b0;
        end else if (w_accept && (in_last != w_is_last_slot)) begin
            r_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire
